high_score_entry: RTL



---
 rtl/high_score_entry_pkg.sv | 88 ++++++++
 rtl/high_score_entry_seg_glyph_rom.sv | 23 ++
 rtl/high_score_entry.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/high_score_entry_pkg.sv
`default_nettype none
// ============================================================================
// high_score_entry_pkg: states, glyph font, text and BCD helper. Rev 1.0
// ============================================================================
package high_score_entry_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CHECK  = 2'd1;
  localparam logic [1:0] ST_ENTRY  = 2'd2;
  localparam logic [1:0] ST_RESULT = 2'd3;

  localparam logic [1:0] SEL_BLANK  = 2'd0;
  localparam logic [1:0] SEL_LETTER = 2'd1;
  localparam logic [1:0] SEL_DIGIT  = 2'd2;

  // Active-low segments, bit order g..a
  localparam logic [6:0] GLY_BLANK = 7'b1111111;
  localparam logic [6:0] GLY_A     = 7'b0001000;
  localparam logic [6:0] GLY_H     = 7'b0001001;
  localparam logic [6:0] GLY_I     = 7'b1001111;
  localparam logic [6:0] GLY_G     = 7'b1000010;
  localparam logic [6:0] GLY_S     = 7'b0010010;
  localparam logic [6:0] GLY_C     = 7'b1000110;
  localparam logic [6:0] GLY_O     = 7'b1000000;
  localparam logic [6:0] GLY_R     = 7'b1001100;

  // Letter indices, first letter in the top field
  localparam logic [19:0] TXT_HIGH = {5'd7, 5'd8, 5'd6, 5'd7};
  localparam logic [19:0] TXT_SCOR = {5'd18, 5'd2, 5'd14, 5'd17};

  function automatic logic [6:0] letter_glyph(input logic [4:0] idx);
    case (idx)
      5'd0:    return GLY_A;
      5'd1:    return 7'b0000011;
      5'd2:    return GLY_C;
      5'd3:    return 7'b0100001;
      5'd4:    return 7'b0000110;
      5'd5:    return 7'b0001110;
      5'd6:    return GLY_G;
      5'd7:    return GLY_H;
      5'd8:    return GLY_I;
      5'd9:    return 7'b1100001;
      5'd10:   return 7'b0001010;
      5'd11:   return 7'b1000111;
      5'd12:   return 7'b1101010;
      5'd13:   return 7'b0101011;
      5'd14:   return GLY_O;
      5'd15:   return 7'b0001100;
      5'd16:   return 7'b0011000;
      5'd17:   return GLY_R;
      5'd18:   return GLY_S;
      5'd19:   return 7'b0000111;
      5'd20:   return 7'b1000001;
      5'd21:   return 7'b1100011;
      5'd22:   return 7'b1010101;
      5'd23:   return 7'b0001001;
      5'd24:   return 7'b0010001;
      5'd25:   return 7'b0100100;
      default: return GLY_BLANK;
    endcase
  endfunction

  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return GLY_BLANK;
    endcase
  endfunction

  function automatic logic [7:0] to_bcd(input logic [5:0] bin);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(bin / 6'd10);
    ones = 4'(bin % 6'd10);
    return {tens, ones};
  endfunction

endpackage
`default_nettype wire

// File: rtl/high_score_entry_seg_glyph_rom.sv
`default_nettype none
// ============================================================================
// seg_glyph_rom: letter index or decimal digit to active-low glyph. Rev 1.0
// ============================================================================
module seg_glyph_rom
  import high_score_entry_pkg::*;
(
  input  logic [1:0] sel,
  input  logic [4:0] letter,
  input  logic [3:0] digit,
  output logic [6:0] glyph
);

  always_comb begin
    case (sel)
      SEL_LETTER: glyph = letter_glyph(letter);
      SEL_DIGIT:  glyph = digit_glyph(digit);
      default:    glyph = GLY_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/high_score_entry.sv
`default_nettype none
// ============================================================================
// high_score_entry: high-score check, initials entry and message display. Rev 1.0
// ============================================================================
module high_score_entry
  import high_score_entry_pkg::*;
#(
  parameter int SCORE_W      = 6,
  parameter int RESULT_TICKS = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_1hz,
  input  logic               game_over,
  input  logic [SCORE_W-1:0] score,
  input  logic               show_req,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_mid,
  output logic [27:0]        msg,
  output logic               new_game,
  output logic [SCORE_W-1:0] hs_score,
  output logic [14:0]        hs_initials,
  output logic               busy
);

  localparam int CNT_W = $clog2(RESULT_TICKS + 1);

  logic [1:0]         state, state_next;
  logic               game_over_q, show_req_q;
  logic [SCORE_W-1:0] cur_score;
  logic [1:0]         phase, cursor;
  logic [14:0]        entry, entry_next;
  logic [4:0]         cur_letter, new_letter;
  logic [CNT_W-1:0]   tick_cnt;
  logic               start, one_press, commit, last_tick;
  logic [7:0]         bcd;
  logic [1:0]         sel    [4];
  logic [4:0]         letter [4];
  logic [3:0]         digit  [4];
  logic [6:0]         glyph  [4];

  assign start     = game_over & ~game_over_q;
  // Parity high and not all three set means exactly one press
  assign one_press = (btn_up ^ btn_down ^ btn_mid) & ~(btn_up & btn_down & btn_mid);
  assign commit    = (state == ST_ENTRY) & one_press & btn_mid & (cursor == 2'd2);
  assign last_tick = (state == ST_RESULT) & tick_1hz &
                     (tick_cnt == CNT_W'(RESULT_TICKS - 1));
  assign bcd       = to_bcd(6'(hs_score));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_CHECK;
      ST_CHECK: state_next = (cur_score > hs_score) ? ST_ENTRY : ST_RESULT;
      ST_ENTRY: if (commit) state_next = ST_RESULT;
      default:  if (last_tick) state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != ST_IDLE);
    new_game = last_tick;
  end

  always_comb begin
    case (cursor)
      2'd0:    cur_letter = entry[14:10];
      2'd1:    cur_letter = entry[9:5];
      default: cur_letter = entry[4:0];
    endcase
    new_letter = cur_letter;
    if (btn_up)        new_letter = (cur_letter == 5'd25) ? 5'd0  : cur_letter + 5'd1;
    else if (btn_down) new_letter = (cur_letter == 5'd0)  ? 5'd25 : cur_letter - 5'd1;
    entry_next = entry;
    case (cursor)
      2'd0:    entry_next[14:10] = new_letter;
      2'd1:    entry_next[9:5]   = new_letter;
      default: entry_next[4:0]   = new_letter;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      game_over_q <= 1'b0;
      show_req_q  <= 1'b0;
      cur_score   <= '0;
      phase       <= 2'd0;
      cursor      <= 2'd0;
      entry       <= '0;
      tick_cnt    <= '0;
      hs_score    <= '0;
      hs_initials <= '0;
    end else begin
      game_over_q <= game_over;
      show_req_q  <= show_req;
      case (state)
        ST_IDLE: begin
          if (start) cur_score <= score;
          if (show_req & ~show_req_q) phase <= 2'd0;
          else if (tick_1hz)          phase <= phase + 2'd1;
        end
        ST_CHECK: begin
          cursor   <= 2'd0;
          entry    <= '0;
          phase    <= 2'd0;
          tick_cnt <= '0;
        end
        ST_ENTRY: begin
          phase    <= 2'd0;
          tick_cnt <= '0;
          if (one_press) begin
            entry <= entry_next;
            if (commit) begin
              hs_score    <= cur_score;
              hs_initials <= entry;
            end else if (btn_mid) begin
              cursor <= cursor + 2'd1;
            end
          end
        end
        default: begin
          if (last_tick) begin
            phase    <= 2'd0;
            tick_cnt <= '0;
          end else if (tick_1hz) begin
            phase    <= phase + 2'd1;
            tick_cnt <= tick_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  // Digit 3 is leftmost; letter fields are stored first-letter-highest
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      sel[i]    = SEL_BLANK;
      letter[i] = '0;
      digit[i]  = '0;
    end
    if (state == ST_ENTRY) begin
      for (int i = 1; i < 4; i++) begin
        sel[i]    = SEL_LETTER;
        letter[i] = entry[5*(i-1) +: 5];
      end
      sel[0]   = SEL_DIGIT;
      digit[0] = {2'b00, cursor} + 4'd1;
    end else if (state == ST_RESULT || (state == ST_IDLE && show_req)) begin
      case (phase)
        2'd0: for (int i = 0; i < 4; i++) begin
          sel[i]    = SEL_LETTER;
          letter[i] = TXT_HIGH[5*i +: 5];
        end
        2'd1: for (int i = 0; i < 4; i++) begin
          sel[i]    = SEL_LETTER;
          letter[i] = TXT_SCOR[5*i +: 5];
        end
        2'd2: for (int i = 1; i < 4; i++) begin
          sel[i]    = SEL_LETTER;
          letter[i] = hs_initials[5*(i-1) +: 5];
        end
        default: begin
          sel[1]   = SEL_DIGIT;
          digit[1] = bcd[7:4];
          sel[0]   = SEL_DIGIT;
          digit[0] = bcd[3:0];
        end
      endcase
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_digit
    seg_glyph_rom u_rom (
      .sel    (sel[g]),
      .letter (letter[g]),
      .digit  (digit[g]),
      .glyph  (glyph[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) msg <= 28'hFFFFFFF;
    else     msg <= {glyph[3], glyph[2], glyph[1], glyph[0]};
  end

endmodule
`default_nettype wire
